// File: rtl/cordic_z_sequencer.sv
// ---------------------------------------------------------------------------
// cordic_z_sequencer
//
// Steps a CORDIC Z-path (angle) datapath through ITER iterations.
// The sequencer holds the current angle, iteration index and rotation
// direction for LAT+1 cycles per iteration. The downstream Z-rotation stage
// turns these into zfb after LAT cycles, and the sequencer captures zfb on
// the last phase cycle of each iteration.
//
// Optional feature (macro CORDIC_Z_FOLD_EN):
//   On start, an angle whose magnitude exceeds pi/2 is folded by pi.
//   quad_flip reports the fold. When the macro is undefined, z0 is loaded
//   unchanged and quad_flip is tied low.
//
// Ports:
//   clock      : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : begin an operation (sampled only in IDLE)
//   z0         : signed initial angle (2^(DSIZE-1) = pi), sampled with start
//   zfb        : signed angle returned by the downstream Z-rotation stage
//   Zin        : signed angle presented to the stage (0 in IDLE)
//   I          : iteration index / LUT address (0 in IDLE)
//   direction  : 1 when Zin >= 0, 0 when Zin < 0 (0 in IDLE)
//   busy       : high whenever the FSM is not in IDLE
//   done       : one-cycle pulse; z_res valid
//   z_res      : final residual angle, held until the next done
//   quad_flip  : z0 was folded by pi (valid with done)
//   state_dbg  : current FSM state (IDLE=0, ITER=1, DONE=2)
//
// Handshake: start is a request with no ready. It is honoured only on a
// rising edge where the FSM is in IDLE. Starts that arrive while busy are
// dropped, not queued.
// ---------------------------------------------------------------------------
module cordic_z_sequencer #(
  parameter int DSIZE = 16,
  parameter int PSIZE = 5,
  parameter int ITER  = 16,
  parameter int LAT   = 2
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [DSIZE-1:0] z0,
  input  logic signed [DSIZE-1:0] zfb,
  output logic signed [DSIZE-1:0] Zin,
  output logic        [PSIZE-1:0] I,
  output logic                    direction,
  output logic                    busy,
  output logic                    done,
  output logic signed [DSIZE-1:0] z_res,
  output logic                    quad_flip,
  output logic        [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The phase counter must be able to hold the value LAT.
  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CW-1:0]    C_LAST = CW'(LAT);
  localparam logic [PSIZE-1:0] K_LAST = PSIZE'(ITER - 1);

  logic [1:0]              state_q, state_d;
  logic [PSIZE-1:0]        k_q, k_d;
  logic [CW-1:0]           c_q, c_d;
  logic signed [DSIZE-1:0] z_reg_q, z_reg_d;
  logic signed [DSIZE-1:0] z_res_q, z_res_d;
  logic signed [DSIZE-1:0] z_load;
  logic                    fold_need;

`ifdef CORDIC_Z_FOLD_EN
  localparam logic signed [DSIZE-1:0] QTR_POS = {2'b01, {(DSIZE-2){1'b0}}};
  localparam logic signed [DSIZE-1:0] QTR_NEG = {2'b11, {(DSIZE-2){1'b0}}};
  localparam logic        [DSIZE-1:0] PI_BIT  = {1'b1, {(DSIZE-1){1'b0}}};

  logic qf_q, qf_d;

  // Flipping the sign bit adds pi modulo 2^DSIZE. The limits are exclusive,
  // so exactly +/- pi/2 is left unfolded.
  always_comb begin
    fold_need = (z0 > QTR_POS) || (z0 < QTR_NEG);
    z_load    = fold_need ? (z0 ^ PI_BIT) : z0;
  end

  always_comb begin
    qf_d = qf_q;
    if (state_q == S_IDLE && start) begin
      qf_d = fold_need;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      qf_q <= 1'b0;
    end else begin
      qf_q <= qf_d;
    end
  end

  assign quad_flip = qf_q;
`else
  always_comb begin
    fold_need = 1'b0;
    z_load    = z0;
  end

  assign quad_flip = fold_need;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    z_reg_d = z_reg_q;
    z_res_d = z_res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ITER;
          z_reg_d = z_load;
          k_d     = '0;
          c_d     = '0;
        end
      end
      S_ITER: begin
        if (c_q == C_LAST) begin
          z_reg_d = zfb;
          c_d     = '0;
          if (k_q == K_LAST) begin
            state_d = S_DONE;
            k_d     = '0;
            // The final capture also loads z_res, so the result is already
            // on the output during the done cycle rather than one cycle
            // later.
            z_res_d = zfb;
          end else begin
            k_d = k_q + PSIZE'(1);
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        k_d     = '0;
        c_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
        c_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      c_q     <= '0;
      z_reg_q <= '0;
      z_res_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      z_reg_q <= z_reg_d;
      z_res_q <= z_res_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign Zin       = busy ? z_reg_q : '0;
  assign I         = busy ? k_q : '0;
  assign direction = busy & ~z_reg_q[DSIZE-1];
  assign z_res     = z_res_q;
  assign state_dbg = state_q;

endmodule
